// File: rtl/even_seq_checker.sv
// even_seq_checker: locks onto a 0,2,..,14 wrapping even-count stream and flags sequence violations
// Ports: clk; clear (async active-low reset); cnt_in/cnt_valid sample input; ack_err restarts
// acquisition after an error; locked/err_flag state flags; wrap_pulse one cycle per accepted 14->0;
// lap_count/err_count saturating counters; last_good last legal sample accepted while locked.
module even_seq_checker #(
  parameter int LOCK_LEN = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [3:0]    cnt_in,
  input  logic          cnt_valid,
  input  logic          ack_err,
  output logic          locked,
  output logic          err_flag,
  output logic          wrap_pulse,
  output logic [CW-1:0] lap_count,
  output logic [CW-1:0] err_count,
  output logic [3:0]    last_good
);
  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_LEN);
  typedef enum logic [1:0] {UNLOCKED, LOCKED, ERROR} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [3:0] prev_q, prev_d, last_good_q, last_good_d;
  logic prev_valid_q, prev_valid_d;
  logic locked_q, locked_d, err_flag_q, err_flag_d, wrap_pulse_q, wrap_pulse_d;
  logic [CW-1:0] lap_q, lap_d, err_q, err_d;
  logic odd, legal, wrap, step_ok;
  assign odd = cnt_in[0];
  // 0 is always accepted since upstream may restart from clear; it only counts as a lap after 14
  assign legal = !odd && (cnt_in == 4'd0 || cnt_in == ((prev_q == 4'd14) ? 4'd0 : prev_q + 4'd2));
  assign wrap = cnt_in == 4'd0 && prev_q == 4'd14;
  assign step_ok = cnt_valid && prev_valid_q && legal;
  assign run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= UNLOCKED;
      run_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      last_good_q  <= '0;
      locked_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      lap_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      last_good_q  <= last_good_d;
      locked_q     <= locked_d;
      err_flag_q   <= err_flag_d;
      wrap_pulse_q <= wrap_pulse_d;
      lap_q        <= lap_d;
      err_q        <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == UNLOCKED && step_ok && run_inc == RUN_MAX) state_d = LOCKED;
    if (state_q == LOCKED && cnt_valid && !legal) state_d = ERROR;
    if (state_q == ERROR && ack_err) state_d = UNLOCKED;
  end
  always_comb begin
    run_d        = run_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    last_good_d  = last_good_q;
    lap_d        = lap_q;
    err_d        = err_q;
    wrap_pulse_d = 1'b0;
    if (state_q == UNLOCKED && cnt_valid) begin
      run_d = step_ok ? run_inc : '0;
      // odd samples break the run but leave the reference point alone
      if (!odd) begin
        prev_d       = cnt_in;
        prev_valid_d = 1'b1;
      end
    end
    if (state_q == LOCKED && cnt_valid && legal) begin
      prev_d       = cnt_in;
      last_good_d  = cnt_in;
      wrap_pulse_d = wrap;
      lap_d        = (wrap && lap_q != '1) ? lap_q + 1'b1 : lap_q;
    end
    if (state_q == LOCKED && cnt_valid && !legal) err_d = (err_q != '1) ? err_q + 1'b1 : err_q;
    if (state_q == ERROR && ack_err) begin
      run_d        = '0;
      prev_valid_d = 1'b0;
    end
    locked_d   = state_d == LOCKED;
    err_flag_d = state_d == ERROR;
  end
  assign locked     = locked_q;
  assign err_flag   = err_flag_q;
  assign wrap_pulse = wrap_pulse_q;
  assign lap_count  = lap_q;
  assign err_count  = err_q;
  assign last_good  = last_good_q;
endmodule

// File: tb/tb_even_seq_checker.sv
// tb_even_seq_checker: table-driven scoreboard bench for even_seq_checker
module tb_even_seq_checker;
  typedef struct {
    logic v; logic [3:0] c; logic a;
    logic lk; logic ef; logic wp; logic [7:0] lp; logic [7:0] er; logic [3:0] lg;
  } vec_t;
  logic clk = 1'b0;
  logic clear = 1'b0;
  logic [3:0] cnt_in = '0;
  logic cnt_valid = 1'b0;
  logic ack_err = 1'b0;
  logic locked, err_flag, wrap_pulse;
  logic [7:0] lap_count, err_count;
  logic [3:0] last_good;
  logic l2, e2, w2;
  logic [1:0] lap2, err2;
  logic [3:0] lg2;
  int n_chk = 0;
  int n_fail = 0;
  int vidx = 0;
  vec_t tbl[$];
  vec_t sb[$];
  even_seq_checker #(.LOCK_LEN(2), .CW(8)) dut (
    .clk(clk), .clear(clear), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .ack_err(ack_err),
    .locked(locked), .err_flag(err_flag), .wrap_pulse(wrap_pulse),
    .lap_count(lap_count), .err_count(err_count), .last_good(last_good)
  );
  even_seq_checker #(.LOCK_LEN(2), .CW(2)) dut2 (
    .clk(clk), .clear(clear), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .ack_err(ack_err),
    .locked(l2), .err_flag(e2), .wrap_pulse(w2),
    .lap_count(lap2), .err_count(err2), .last_good(lg2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [3:0] c, input logic a, input logic lk, input logic ef,
                     input logic wp, input logic [7:0] lp, input logic [7:0] er, input logic [3:0] lg);
    vec_t t;
    t.v = v; t.c = c; t.a = a; t.lk = lk; t.ef = ef; t.wp = wp; t.lp = lp; t.er = er; t.lg = lg;
    tbl.push_back(t);
  endtask
  task automatic step(input vec_t t);
    vec_t e;
    string p;
    @(negedge clk);
    cnt_valid = t.v; cnt_in = t.c; ack_err = t.a;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    p = $sformatf("v%0d", vidx++);
    chk({p, ".locked"}, {7'b0, locked}, {7'b0, e.lk});
    chk({p, ".err_flag"}, {7'b0, err_flag}, {7'b0, e.ef});
    chk({p, ".wrap_pulse"}, {7'b0, wrap_pulse}, {7'b0, e.wp});
    chk({p, ".lap_count"}, lap_count, e.lp);
    chk({p, ".err_count"}, err_count, e.er);
    chk({p, ".last_good"}, {4'b0, last_good}, {4'b0, e.lg});
  endtask
  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    tbl.delete();
  endtask
  task automatic zeros(input string p);
    chk({p, ".locked"}, {7'b0, locked}, 8'd0);
    chk({p, ".err_flag"}, {7'b0, err_flag}, 8'd0);
    chk({p, ".wrap_pulse"}, {7'b0, wrap_pulse}, 8'd0);
    chk({p, ".lap_count"}, lap_count, 8'd0);
    chk({p, ".err_count"}, err_count, 8'd0);
    chk({p, ".last_good"}, {4'b0, last_good}, 8'd0);
    chk({p, ".err_count_cw2"}, {6'b0, err2}, 8'd0);
  endtask
  task automatic pulse_clear(input string p);
    @(negedge clk);
    #2 clear = 1'b0;
    cnt_valid = 1'b0; ack_err = 1'b0;
    #1 zeros(p);
    @(negedge clk);
    clear = 1'b1;
  endtask
  initial begin
    #12 zeros("reset");
    @(negedge clk);
    clear = 1'b1;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6, 0, 1, 0, 0, 0, 0, 6);
    add(1, 8, 0, 1, 0, 0, 0, 0, 8);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(1, 4'(2 * k), 0, 1, 0, 0, 0, 0, 4'(2 * k));
    add(1, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 5, 0, 1, 0, 0, 1, 0, 0);
    add(1, 2, 0, 1, 0, 0, 1, 0, 2);
    add(1, 4, 0, 1, 0, 0, 1, 0, 4);
    add(1, 6, 0, 1, 0, 0, 1, 0, 6);
    add(1, 9, 0, 0, 1, 0, 1, 1, 6);
    add(1, 8, 0, 0, 1, 0, 1, 1, 6);
    add(1, 8, 1, 0, 0, 0, 1, 1, 6);
    add(1, 10, 0, 0, 0, 0, 1, 1, 6);
    add(1, 12, 0, 0, 0, 0, 1, 1, 6);
    add(1, 14, 0, 1, 0, 0, 1, 1, 6);
    add(0, 0, 1, 1, 0, 0, 1, 1, 6);
    add(1, 0, 0, 1, 0, 1, 2, 1, 0);
    add(1, 3, 0, 0, 1, 0, 2, 2, 0);
    add(0, 0, 1, 0, 0, 0, 2, 2, 0);
    add(1, 4, 0, 0, 0, 0, 2, 2, 0);
    add(1, 6, 0, 0, 0, 0, 2, 2, 0);
    add(1, 7, 0, 0, 0, 0, 2, 2, 0);
    add(1, 8, 0, 0, 0, 0, 2, 2, 0);
    add(1, 10, 0, 1, 0, 0, 2, 2, 0);
    add(1, 10, 0, 0, 1, 0, 2, 3, 0);
    add(0, 0, 1, 0, 0, 0, 2, 3, 0);
    add(1, 2, 1, 0, 0, 0, 2, 3, 0);
    add(1, 4, 0, 0, 0, 0, 2, 3, 0);
    add(1, 4, 0, 0, 0, 0, 2, 3, 0);
    add(1, 6, 0, 0, 0, 0, 2, 3, 0);
    add(1, 8, 0, 1, 0, 0, 2, 3, 0);
    for (int k = 0; k < 4; k++) add(0, 4'(2 * k + 1), 0, 1, 0, 0, 2, 3, 0);
    add(1, 10, 0, 1, 0, 0, 2, 3, 10);
    for (int k = 0; k < 4; k++) add(0, 4'(k + 3), 0, 1, 0, 0, 2, 3, 10);
    add(1, 12, 0, 1, 0, 0, 2, 3, 12);
    run_tbl();
    pulse_clear("midclear");
    add(1, 14, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0, 0, 0);
    run_tbl();
    pulse_clear("satclear");
    for (int i = 0; i < 4; i++) begin
      add(1, 0, 0, 0, 0, 0, 0, 8'(i), 0);
      add(1, 2, 0, 0, 0, 0, 0, 8'(i), 0);
      add(1, 4, 0, 1, 0, 0, 0, 8'(i), 0);
      add(1, 5, 0, 0, 1, 0, 0, 8'(i + 1), 0);
      add(0, 0, 1, 0, 0, 0, 0, 8'(i + 1), 0);
      run_tbl();
      chk($sformatf("sat_err_cw2_%0d", i), {6'b0, err2}, (i >= 2) ? 8'd3 : 8'(i + 1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/even_seq_checker.md
EVEN_SEQ_CHECKER -- requirements
Module: even_seq_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 2, meaning the number of consecutive legal transitions required to enter LOCKED.
REQ-002 SHALL have parameter CW, default 8, meaning the width of the lap and error counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cnt_in, input, 4, the count value sampled from the even-counter stage.
REQ-006 SHALL have port cnt_valid, input, 1, qualifying cnt_in as one new sample this cycle.
REQ-007 SHALL have port ack_err, input, 1, acknowledging an error and restarting lock acquisition.
REQ-008 SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-009 SHALL have port err_flag, output, 1, high while the FSM is in ERROR.
REQ-010 SHALL have port wrap_pulse, output, 1, a one-cycle pulse on each accepted 14->0 wrap.
REQ-011 SHALL have port lap_count, output, CW, counting accepted wraps.
REQ-012 SHALL have port err_count, output, CW, counting sequence violations.
REQ-013 SHALL have port last_good, output, 4, the last sample accepted as legal in LOCKED.

Function
REQ-014 SHALL define legal successor of prev p as: 0 if p==14, else p+2; additionally sample 0 SHALL always be legal (upstream clear restart) but counts as a wrap only when p==14.
REQ-015 SHALL treat any odd sample, any repeat of prev, and any other even value as illegal.
REQ-016 SHALL ignore cnt_in entirely on cycles where cnt_valid==0; no state, counter or prev change.
REQ-017 SHALL implement FSM states UNLOCKED, LOCKED, ERROR.
REQ-018 UNLOCKED: odd sample -> run=0, prev unchanged, prev_valid unchanged.
REQ-019 UNLOCKED: even sample with prev_valid and legal -> run+1; otherwise run=0; in both cases prev<=sample, prev_valid<=1.
REQ-020 UNLOCKED: when run reaches LOCK_LEN, next state LOCKED; locked rises on that same edge.
REQ-021 LOCKED: legal sample -> stay, prev<=sample, last_good<=sample.
REQ-022 LOCKED: legal sample 0 with prev==14 -> wrap_pulse high for exactly the next cycle, lap_count+1.
REQ-023 LOCKED: illegal sample -> ERROR, err_count+1, prev and last_good unchanged, no wrap_pulse.
REQ-024 ERROR: samples ignored; ack_err==1 -> UNLOCKED with run=0, prev_valid=0; err_count and lap_count retained.
REQ-025 ack_err SHALL be ignored in UNLOCKED and LOCKED.
REQ-026 ack_err and cnt_valid together in ERROR: ack wins, sample discarded.
REQ-027 lap_count and err_count SHALL saturate at 2^CW-1, never wrapping.
REQ-028 All outputs SHALL be registered; response latency 1 clk after the sampling edge.
REQ-029 run counter SHALL be wide enough for LOCK_LEN and never exceed it.

Reset
REQ-030 clear==0 SHALL asynchronously force state UNLOCKED, run=0, prev=0, prev_valid=0, locked=0, err_flag=0, wrap_pulse=0, lap_count=0, err_count=0, last_good=0.
REQ-031 Reset mid-operation SHALL discard all history; first sample after release is treated as first-ever sample.
REQ-032 Release of clear SHALL take effect on the first rising clk edge with clear==1.

Verification
REQ-033 Samples 0,2,4 valid every cycle -> locked=1 one cycle after the 4 sample; lap_count=0, err_count=0.
REQ-034 Locked, samples 12,14,0 -> wrap_pulse high exactly one cycle after 0 sampled; lap_count=1; last_good=0.
REQ-035 Locked at 6, sample 9 -> err_flag=1, locked=0, err_count=1, last_good=6; further samples ignored; ack_err=1 -> UNLOCKED, err_flag=0, err_count stays 1.
REQ-036 Locked at 8, sample 0 (restart) -> stays locked, no wrap_pulse, lap_count unchanged.
REQ-037 Locked, 4-cycle gaps with cnt_valid=0 between legal samples -> no state change; clear pulsed low mid-stream -> all outputs 0 immediately, relock needs LOCK_LEN fresh transitions.
REQ-038 CW=2, force 4 violations with ack between each -> err_count saturates at 3.
